// File: rtl/fifo_wr_ctrl.sv
// Write-side front end for the async FIFO: 2-entry skid buffer feeding the FIFO write port,
// with per-burst word counting. Optional stall timeout flag under WR_STALL_TIMEOUT_EN.
module fifo_wr_ctrl #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic                           wclk,
    input  logic                           reset,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [DATA_W-1:0]              s_data,
    input  logic                           s_last,
    input  logic                           fifo_full,
    output logic                           fifo_we,
    output logic [DATA_W-1:0]              fifo_wdata,
    output logic [$clog2(MAX_BURST+1)-1:0] burst_cnt,
    output logic                           burst_done,
    output logic                           stall_err
);

    localparam int CW = $clog2(MAX_BURST+1);

    typedef enum logic [1:0] {IDLE, ACTIVE, STALL} state_t;

    logic [DATA_W-1:0] data_q [2];
    logic [DATA_W-1:0] data_d [2];
    logic              last_q [2];
    logic              last_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        occ_q, occ_d;
    state_t            state_q, state_d;
    logic [CW-1:0]     burst_cnt_q, burst_cnt_d;
    logic              burst_done_q, burst_done_d;
    logic [CW-1:0]     cnt_base;
    logic              push, pop, head_last;

    // s_ready depends only on registered occupancy; writes are suppressed while reset is held
    assign s_ready    = (occ_q != 2'd2);
    assign push       = s_valid && s_ready;
    assign fifo_we    = (occ_q != 2'd0) && !fifo_full && !reset;
    assign pop        = fifo_we;
    assign head_last  = (occ_q != 2'd0) && last_q[rd_ptr_q];
    assign fifo_wdata = (occ_q != 2'd0) ? data_q[rd_ptr_q] : '0;
    assign burst_cnt  = burst_cnt_q;
    assign burst_done = burst_done_q;

    always_comb begin
        data_d   = data_q;
        last_d   = last_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            data_d[wr_ptr_q] = s_data;
            last_d[wr_ptr_q] = s_last;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        occ_d = occ_q + 2'(push) - 2'(pop);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pop)
                    state_d = head_last ? IDLE : ACTIVE;
                else if (occ_q != 2'd0 && fifo_full)
                    state_d = STALL;
            end
            ACTIVE: begin
                if (pop && head_last)
                    state_d = IDLE;
                else if (occ_q != 2'd0 && fifo_full)
                    state_d = STALL;
            end
            STALL: begin
                if (!fifo_full)
                    state_d = ACTIVE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The final count is shown alongside burst_done, then restarts from zero
    always_comb begin
        cnt_base     = burst_done_q ? '0 : burst_cnt_q;
        burst_cnt_d  = cnt_base;
        burst_done_d = pop && head_last;
        if (pop) begin
            if (cnt_base != CW'(MAX_BURST))
                burst_cnt_d = cnt_base + 1'b1;
        end
    end

    always_ff @(posedge wclk) begin
        if (reset) begin
            data_q[0]    <= '0;
            data_q[1]    <= '0;
            last_q[0]    <= 1'b0;
            last_q[1]    <= 1'b0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            occ_q        <= 2'd0;
            state_q      <= IDLE;
            burst_cnt_q  <= '0;
            burst_done_q <= 1'b0;
        end else begin
            data_q       <= data_d;
            last_q       <= last_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            state_q      <= state_d;
            burst_cnt_q  <= burst_cnt_d;
            burst_done_q <= burst_done_d;
        end
    end

`ifdef WR_STALL_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT+1);

    logic [SW-1:0] stall_cnt_q, stall_cnt_d;
    logic          stall_err_q, stall_err_d;

    // Counts consecutive cycles spent in STALL; the flag is sticky until reset
    always_comb begin
        stall_cnt_d = '0;
        stall_err_d = stall_err_q;
        if (state_q == STALL) begin
            stall_cnt_d = (stall_cnt_q == SW'(TIMEOUT)) ? stall_cnt_q : stall_cnt_q + 1'b1;
            if (stall_cnt_q == SW'(TIMEOUT-1))
                stall_err_d = 1'b1;
        end
    end

    always_ff @(posedge wclk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            stall_err_q <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            stall_err_q <= stall_err_d;
        end
    end

    assign stall_err = stall_err_q;
`else
    localparam int unused_timeout = TIMEOUT;

    assign stall_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl: directed scenarios plus a random phase, all
// compared every cycle against a queue-based reference model.
module tb_fifo_wr_ctrl;

    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 8;
    localparam int TIMEOUT   = 16;
    localparam int CW        = $clog2(MAX_BURST+1);

    logic              wclk = 1'b0;
    logic              reset;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              fifo_full;
    logic              fifo_we;
    logic [DATA_W-1:0] fifo_wdata;
    logic [CW-1:0]     burst_cnt;
    logic              burst_done;
    logic              stall_err;

    fifo_wr_ctrl #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)) dut (
        .wclk(wclk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .fifo_full(fifo_full), .fifo_we(fifo_we),
        .fifo_wdata(fifo_wdata), .burst_cnt(burst_cnt), .burst_done(burst_done),
        .stall_err(stall_err)
    );

    always #5 wclk = ~wclk;

    // Reference model: buffered words {last,data} in order, plus burst and stall bookkeeping
    logic [DATA_W:0] m_q[$];
    int              m_cnt;
    bit              m_done;
    bit              m_stall;
    int              m_run;
    bit              m_err;
    int              pass_cnt  = 0;
    int              total_cnt = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic modelReset();
        m_q.delete();
        m_cnt   = 0;
        m_done  = 0;
        m_stall = 0;
        m_run   = 0;
        m_err   = 0;
    endtask

    // One clock cycle: drive, check outputs before the edge, then advance the model
    task automatic applyStimulus(input bit rst, input bit v, input logic [DATA_W-1:0] d,
                                 input bit l, input bit f);
        bit exp_we, push, hl;
        reset     = rst;
        s_valid   = v;
        s_data    = d;
        s_last    = l;
        fifo_full = f;
        #1;
        exp_we = !rst && (m_q.size() != 0) && !f;
        checkOutput("s_ready",    32'(s_ready),    32'(m_q.size() < 2));
        checkOutput("fifo_we",    32'(fifo_we),    32'(exp_we));
        checkOutput("fifo_wdata", 32'(fifo_wdata), (m_q.size() != 0) ? 32'(m_q[0][DATA_W-1:0]) : 32'd0);
        checkOutput("burst_cnt",  32'(burst_cnt),  32'(m_cnt));
        checkOutput("burst_done", 32'(burst_done), 32'(m_done));
        checkOutput("stall_err",  32'(stall_err),  32'(m_err));
        @(posedge wclk);
        if (rst) begin
            modelReset();
        end else begin
            push = v && (m_q.size() < 2);
            hl   = (m_q.size() != 0) && m_q[0][DATA_W];
            m_run = m_stall ? m_run + 1 : 0;
`ifdef WR_STALL_TIMEOUT_EN
            if (m_run >= TIMEOUT) m_err = 1;
`endif
            m_stall = m_stall ? f : ((m_q.size() != 0) && f);
            if (exp_we) begin
                m_cnt = (m_done ? 0 : m_cnt) + 1;
                if (m_cnt > MAX_BURST) m_cnt = MAX_BURST;
            end else if (m_done) begin
                m_cnt = 0;
            end
            m_done = exp_we && hl;
            if (exp_we) void'(m_q.pop_front());
            if (push) m_q.push_back({l, d});
        end
        @(negedge wclk);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, 0, 0);
    endtask

    initial begin
        int idx;
        reset = 1; s_valid = 0; s_data = '0; s_last = 0; fifo_full = 0;
        modelReset();
        @(posedge wclk);
        @(posedge wclk);
        @(negedge wclk);

        $display("[TB] reset state");
        applyStimulus(1, 0, '0, 0, 0);
        applyStimulus(0, 0, '0, 0, 0);

        $display("[TB] streaming burst");
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 8'h11 + 8'(i), i == 3, 0);
        idleCycles(3);

        $display("[TB] backpressure");
        idx = 0;
        for (int c = 0; c < 9; c++) begin
            bit acc;
            acc = (m_q.size() < 2);
            applyStimulus(0, idx < 3, 8'h21 + 8'(idx), idx == 2, c < 5);
            if (idx < 3 && acc) idx++;
        end
        idleCycles(3);

        $display("[TB] push and pop together");
        for (int i = 0; i < 11; i++) applyStimulus(0, 1, 8'h30 + 8'(i), i == 10, 0);
        idleCycles(3);

        $display("[TB] saturation");
        for (int i = 0; i < 12; i++) applyStimulus(0, 1, 8'h40 + 8'(i), i == 11, 0);
        idleCycles(3);

        $display("[TB] stall timeout");
        applyStimulus(0, 1, 8'h50, 1, 1);
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, '0, 0, 1);
        idleCycles(3);
`ifdef WR_STALL_TIMEOUT_EN
        checkOutput("stall_err_sticky", 32'(stall_err), 32'd1);
`else
        checkOutput("stall_err_tied", 32'(stall_err), 32'd0);
`endif

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(0, ($urandom % 4) != 0, 8'($urandom), ($urandom % 4) == 0,
                          ($urandom % 3) == 0);
        end

        $display("[TB] reset with full buffer");
        applyStimulus(0, 1, 8'h61, 0, 1);
        applyStimulus(0, 1, 8'h62, 1, 1);
        applyStimulus(0, 1, 8'h63, 0, 1);
        applyStimulus(1, 1, 8'h64, 0, 0);
        applyStimulus(1, 1, 8'h65, 0, 0);
        idleCycles(3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
